// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M iterative multiply/divide unit.
package muldiv_pkg;
    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } funct3_e;
    typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} state_e;
    localparam int MD_STEPS = 32;
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shared hi/lo accumulator for radix-2 shift-add multiply and restoring divide,
// with operand magnitude capture, special-case results and final sign correction.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int W = MD_STEPS
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         load,
    input  logic         step,
    input  logic         finish,
    input  funct3_e      funct3,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         special,
    output logic [W-1:0] result
);
    logic [W-1:0] hi, lo, mcand, mag_a, mag_b, spec_res, nhi, nlo, quo, rem, fin;
    logic [W:0] sum, shl, diff;
    logic [2*W-1:0] prod;
    logic sa, sb, div0, ovf, ge, neg_q, neg_r;
    funct3_e op;
    assign sa = funct3 inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    assign sb = funct3 inside {MD_MULH, MD_DIV, MD_REM};
    assign mag_a = (sa && op_a[W-1]) ? -op_a : op_a;
    assign mag_b = (sb && op_b[W-1]) ? -op_b : op_b;
    assign div0 = funct3[2] && op_b == {W{1'b0}};
    assign ovf = funct3 inside {MD_DIV, MD_REM} && op_a == {1'b1, {W-1{1'b0}}} && &op_b;
    assign special = div0 || ovf;
    assign spec_res = funct3[1] ? (div0 ? op_a : {W{1'b0}}) : (div0 ? {W{1'b1}} : op_a);
    // hi holds the partial product or running remainder; lo the multiplier or quotient
    assign sum = {1'b0, hi} + {1'b0, (lo[0] ? mcand : {W{1'b0}})};
    assign shl = {hi, lo[W-1]};
    assign diff = shl - {1'b0, mcand};
    assign ge = !diff[W];
    assign nhi = op[2] ? (ge ? diff[W-1:0] : shl[W-1:0]) : sum[W:1];
    assign nlo = op[2] ? {lo[W-2:0], ge} : {sum[0], lo[W-1:1]};
    assign prod = neg_q ? -{nhi, nlo} : {nhi, nlo};
    assign quo = neg_q ? -nlo : nlo;
    assign rem = neg_r ? -nhi : nhi;
    assign fin = !op[2] ? (op == MD_MUL ? prod[W-1:0] : prod[2*W-1:W]) : (op[1] ? rem : quo);
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            hi <= '0;
            lo <= '0;
            mcand <= '0;
            op <= MD_MUL;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            result <= '0;
        end else if (load) begin
            hi <= '0;
            lo <= mag_a;
            mcand <= mag_b;
            op <= funct3;
            neg_q <= (sa && op_a[W-1]) ^ (sb && op_b[W-1]);
            neg_r <= sa && op_a[W-1];
            if (special) result <= spec_res;
        end else if (step) begin
            hi <= nhi;
            lo <= nlo;
            if (finish) result <= fin;
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: IDLE/RUN/DONE controller that stalls the pipeline while muldiv_datapath
// iterates, then pulses doneM with the result and destination register.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = MD_STEPS,
    parameter int RF_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  startE,
    input  logic                  abortE,
    input  logic [2:0]            funct3E,
    input  logic [DATA_WIDTH-1:0] opAE,
    input  logic [DATA_WIDTH-1:0] opBE,
    input  logic [RF_WIDTH-1:0]   regAddr3E,
    output logic                  stallMD,
    output logic                  doneM,
    output logic [DATA_WIDTH-1:0] resultM,
    output logic [RF_WIDTH-1:0]   regAddr3M
);
    localparam int CW = $clog2(DATA_WIDTH);
    state_e state;
    logic [CW-1:0] cnt;
    logic [RF_WIDTH-1:0] rd;
    logic load, step, finish, special;
    assign load = state == MD_IDLE && startE && !abortE;
    assign step = state == MD_RUN && !abortE;
    assign finish = step && cnt == CW'(DATA_WIDTH - 1);
    assign stallMD = load || state == MD_RUN;
    muldiv_datapath #(.W(DATA_WIDTH)) u_dp (
        .clk(clk),
        .rstN(rstN),
        .load(load),
        .step(step),
        .finish(finish),
        .funct3(funct3_e'(funct3E)),
        .op_a(opAE),
        .op_b(opBE),
        .special(special),
        .result(resultM)
    );
    // regAddr3M moves only with a result so it always pairs with resultM
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= MD_IDLE;
            cnt <= '0;
            rd <= '0;
            doneM <= 1'b0;
            regAddr3M <= '0;
        end else begin
            doneM <= 1'b0;
            case (state)
                MD_IDLE: if (load) begin
                    cnt <= '0;
                    rd <= regAddr3E;
                    state <= special ? MD_DONE : MD_RUN;
                    if (special) begin
                        doneM <= 1'b1;
                        regAddr3M <= regAddr3E;
                    end
                end
                MD_RUN: if (abortE) state <= MD_IDLE;
                    else if (finish) begin
                        state <= MD_DONE;
                        doneM <= 1'b1;
                        regAddr3M <= rd;
                    end else cnt <= cnt + 1'b1;
                default: state <= MD_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed RV32M vectors checked per cycle against an arithmetic reference model.
module tb_muldiv_sequencer;
    logic clk = 0, rstN = 0, startE = 0, abortE = 0;
    logic [2:0] funct3E = 0;
    logic [31:0] opAE = 0, opBE = 0, resultM;
    logic [4:0] regAddr3E = 0, regAddr3M;
    logic stallMD, doneM;
    int tests = 0, fails = 0, cyc = 0, ts;
    int t0 = -1000, lat = 1, abort_at = 1 << 30;
    logic [31:0] exp_res = 0, hold_res = 0;
    logic [4:0] exp_rd = 0, hold_rd = 0;
    logic exp_done, exp_stall;

    muldiv_sequencer dut (
        .clk(clk), .rstN(rstN), .startE(startE), .abortE(abortE), .funct3E(funct3E),
        .opAE(opAE), .opBE(opBE), .regAddr3E(regAddr3E), .stallMD(stallMD), .doneM(doneM),
        .resultM(resultM), .regAddr3M(regAddr3M)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        ovf = a == 32'h80000000 && b == 32'hFFFFFFFF;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (ovf) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    // every cycle: outputs against the model's view of the op in flight
    always @(negedge clk) begin
        if (!rstN) begin
            hold_res = 0;
            hold_rd = 0;
            check("rst_stall", stallMD, 0);
            check("rst_done", doneM, 0);
            check("rst_result", resultM, 0);
            check("rst_rd", regAddr3M, 0);
        end else begin
            exp_done = cyc == t0 + lat && abort_at >= t0 + lat;
            exp_stall = cyc >= t0 && cyc < t0 + lat && cyc <= abort_at;
            if (exp_done) begin
                hold_res = exp_res;
                hold_rd = exp_rd;
            end
            check("stall", stallMD, exp_stall);
            check("done", doneM, exp_done);
            check("result", resultM, hold_res);
            check("rd", regAddr3M, hold_rd);
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        funct3E = f3;
        opAE = a;
        opBE = b;
        regAddr3E = rd;
        startE = 1;
        t0 = cyc;
        abort_at = 1 << 30;
        lat = is_special(f3, a, b) ? 1 : 33;
        exp_res = ref_res(f3, a, b);
        exp_rd = rd;
        @(posedge clk);
        #1 startE = 0;
    endtask

    task automatic run(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] lit, input int lit_lat);
        int st;
        bit seen;
        st = cyc;
        seen = 0;
        issue(f3, a, b, rd);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = doneM;
        end
        check({name, "_seen"}, 32'(seen), 1);
        if (seen) begin
            check(name, resultM, lit);
            check({name, "_lat"}, cyc - st, lit_lat);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        check("pin_mul", ref_res(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
        check("pin_mulh", ref_res(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'h0);
        check("pin_mulhsu", ref_res(3'd2, 32'hFFFFFFFF, 32'd2), 32'hFFFFFFFF);
        check("pin_rem", ref_res(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
        repeat (3) @(posedge clk);
        #1 rstN = 1;
        @(posedge clk);
        #1;
        run("mul_7x-3", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 33);
        run("mulhu_max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFE, 33);
        run("mulh_m1", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'h0, 33);
        run("div_-7/2", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd8, 32'hFFFFFFFD, 33);
        run("rem_-7/2", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFF, 33);
        run("divu_5/0", 3'd5, 32'd5, 32'd0, 5'd10, 32'hFFFFFFFF, 1);
        run("remu_5/0", 3'd7, 32'd5, 32'd0, 5'd11, 32'd5, 1);
        run("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1);
        run("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h0, 1);
        run("divu_big", 3'd5, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h0, 33);
        run("divu_max/3", 3'd5, 32'hFFFFFFFF, 32'd3, 5'd15, 32'h55555555, 33);
        run("remu_100/7", 3'd7, 32'd100, 32'd7, 5'd16, 32'd2, 33);
        run("div_-100/7", 3'd4, 32'hFFFFFF9C, 32'd7, 5'd17, 32'hFFFFFFF2, 33);
        run("rem_-100/7", 3'd6, 32'hFFFFFF9C, 32'd7, 5'd18, 32'hFFFFFFFE, 33);
        run("mulhsu_min", 3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 33);
        run("mul_wrap", 3'd0, 32'h00010000, 32'h00010000, 5'd20, 32'h0, 33);
        ts = cyc;
        issue(3'd4, 32'd100, 32'd7, 5'd3);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        abortE = 1;
        abort_at = cyc;
        @(posedge clk);
        #1 abortE = 0;
        check("abort_stall_low", stallMD, 0);
        check("abort_offset", cyc - ts, 11);
        @(posedge clk);
        #1;
        run("mul_after_abort", 3'd0, 32'd3, 32'd4, 5'd21, 32'd12, 33);
        issue(3'd0, 32'h1234, 32'h5678, 5'd9);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rstN = 0;
        t0 = -1000;
        #1;
        check("async_rst_result", resultM, 0);
        check("async_rst_rd", regAddr3M, 0);
        check("async_rst_stall", stallMD, 0);
        repeat (2) @(posedge clk);
        #1 rstN = 1;
        @(posedge clk);
        #1;
        run("mulhsu_after_rst", 3'd2, 32'hFFFFFFFF, 32'd2, 5'd22, 32'hFFFFFFFF, 33);
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
